ibex_fp_wb_stage: RTL
=====================

// Module: ibex_fp_wb_stage
// PURPOSE
// - Writeback stage directly downstream of the execute block. Buffers each EX result in order.
// - Routes each buffered result to the integer or FP register file write port.
// - Arbitrates both ports against LSU load responses; the LSU always wins.
// - Accumulates sticky FP exception flags (fflags) at retirement.
// - Reports pending destination registers to ID for hazard stalls.
// PARAMETERS
// - Depth            2   buffer entries; power of two, >= 2
// - FpFlagsEn        1   1: fflags accumulation present; 0: fflags_o tied to 0
// PORTS
// - clk_i            in   1   clock
// - rst_ni           in   1   asynchronous active-low reset
// - ex_valid_i       in   1   EX result valid this cycle
// - ex_ready_o       out  1   buffer can accept (count < Depth)
// - ex_result_i      in   32  EX result data
// - ex_rd_addr_i     in   5   destination register
// - ex_rd_fp_i       in   1   1: FP regfile, 0: integer regfile
// - ex_rd_we_i       in   1   result writes a register
// - ex_fflags_i      in   5   NV,DZ,OF,UF,NX from FPU
// - ex_fflags_we_i   in   1   ex_fflags_i is meaningful
// - lsu_we_i         in   1   load response writes a register this cycle
// - lsu_rd_fp_i      in   1   load targets FP regfile (FLW)
// - rf_we_o          out  1   integer regfile write enable
// - rf_waddr_o       out  5   integer write address
// - rf_wdata_o       out  32  integer write data
// - fp_rf_we_o       out  1   FP regfile write enable
// - fp_rf_waddr_o    out  5   FP write address
// - fp_rf_wdata_o    out  32  FP write data
// - fflags_wr_i      in   1   CSR write to fflags
// - fflags_wdata_i   in   5   CSR write data
// - fflags_o         out  5   sticky accumulated flags
// - id_rs_addr_i     in   5x3 ID source addresses rs1..rs3, packed [14:0]
// - id_rs_fp_i       in   3   per-source FP-regfile flag
// - id_hazard_o      out  3   per-source hit on a buffered, not-yet-written rd
// - wb_empty_o       out  1   no buffered entries; used for fence and debug entry
// BEHAVIOUR
// - Reset (async, rst_ni=0): buffer emptied, pointers and count 0.
//   - All we outputs 0, all addresses and data 0, fflags_o=0.
//   - id_hazard_o=0, ex_ready_o=1, wb_empty_o=1.
//   - Reset mid-operation discards all entries; no partial write is issued.
// - Push condition: ex_valid_i & ex_ready_o & (ex_rd_we_i | ex_fflags_we_i).
//   - Valid results with neither write nor flags are dropped and still count as accepted.
// - ex_ready_o is derived from the registered count only.
//   - Full blocks a push even when a pop occurs in the same cycle. No combinational ready path.
// - Latency: an accepted entry is at the earliest visible on rf/fp_rf outputs in the next cycle.
//   - There is no flow-through from ex_* to the write ports.
// - Drain (head only, strictly in order):
//   - port_busy = lsu_we_i & (lsu_rd_fp_i == head.rd_fp).
//   - pop = valid_head & ~port_busy.
//   - While busy the head stalls and younger entries wait, including those for the other regfile.
// - Write outputs are combinational from the head and pop; they are not registered.
//   - rf_we_o = pop & head.rd_we & ~head.rd_fp & (head.rd != 0).
//   - fp_rf_we_o = pop & head.rd_we & head.rd_fp. f0 is a real register.
//   - Addresses and data follow the head whenever an entry is valid, otherwise they are 0.
// - fflags, when FpFlagsEn=1:
//   - ret_flags = pop & head.fflags_we ? head.fflags : 0.
//   - next = (fflags_wr_i ? fflags_wdata_i : fflags_o) | ret_flags.
//   - A retiring op is never lost to a simultaneous CSR write.
// - Hazard: id_hazard_o[i] = OR over valid entries of (rd_we & rd==rs[i] & rd_fp==rs_fp[i]).
//   - Integer x0 never hits.
//   - An entry popping this cycle still counts as a hit (conservative).
// - Pointers wrap modulo Depth. Simultaneous push and pop with count=1 leaves the count unchanged.
// STRUCTURE
// - Shared package: ibex_pkg gains the packed struct wb_entry_t.
//   - Fields: rd_addr[4:0], rd_fp, rd_we, result[31:0], fflags[4:0], fflags_we.
// - Shared package: ibex_fp_pkg gains the constant FFLAGS_W=5 and the flag bit indices.
// - One sub-module: ibex_wb_fifo.
//   - Parameterised-type FIFO with a full/empty registered count.
//   - Exposes all entries for the hazard compare.
//   - Arbitration, fflags and hazard logic stay in the top level.
// TESTING
// - Single int ALU op: rd=5, data 0xDEADBEEF -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF.
// - Back-to-back FP ops f3, f4 with lsu_we_i=1, lsu_rd_fp_i=1 for 3 cycles:
//   - ex_ready_o=0 after two pushes; no fp_rf_we_o for 3 cycles.
//   - Then f3 and f4 are written in order.
// - Int op to x0 with fflags 5'b00001:
//   - rf_we_o stays 0; fflags_o=5'b00001 after the pop.
//   - A following CSR write of 0 in the same cycle as a retire with NV gives fflags_o=5'b10000.
// - Head FP entry stalled by an FP load, int entry behind it:
//   - The int write waits until the FP entry drains (ordering).
// - Hazard: buffered int x7 with ID rs2=7, rs_fp=0 -> id_hazard_o=3'b010.
//   - rs_fp=1 at the same address -> 3'b000.
// - Assert rst_ni low with 2 entries stalled:
//   - All outputs 0 immediately, ex_ready_o=1, and no write after release.

Source files
------------

// File: rtl/ibex_fp_pkg.sv
// ibex_fp_pkg: floating-point constants shared by the FP datapath.
//   FFLAGS_W       width of the RISC-V fflags CSR
//   FFLAG_*        bit positions of the individual exception flags
package ibex_fp_pkg;

    localparam int unsigned FFLAGS_W = 5;

    localparam int unsigned FFLAG_NV = 4;  // invalid operation
    localparam int unsigned FFLAG_DZ = 3;  // divide by zero
    localparam int unsigned FFLAG_OF = 2;  // overflow
    localparam int unsigned FFLAG_UF = 1;  // underflow
    localparam int unsigned FFLAG_NX = 0;  // inexact

endpackage

// File: rtl/ibex_pkg.sv
// ibex_pkg: core-wide types.
//   wb_entry_t     one buffered execute result waiting for writeback
package ibex_pkg;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic        rd_fp;      // 1: FP regfile, 0: integer regfile
        logic        rd_we;      // result writes a register
        logic [31:0] result;
        logic [4:0]  fflags;     // NV,DZ,OF,UF,NX
        logic        fflags_we;  // fflags field is meaningful
    } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fifo.sv
// ibex_wb_fifo: in-order FIFO of an arbitrary packed type with a registered
// occupancy count. Every slot is exposed together with a per-slot valid bit
// so the parent can compare against all in-flight entries.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write one entry (ignored when full)
//   pop_i          retire the head (ignored when empty)
//   head_o         oldest entry
//   full_o/empty_o derived from the registered count only
//   entries_o      all storage slots, indexed by physical position
//   valid_o        per-slot occupancy
module ibex_wb_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 head_o,
    output logic             full_o,
    output logic             empty_o,
    output T                 entries_o [Depth],
    output logic [Depth-1:0] valid_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_en, pop_en;
    T                mem_q [Depth];

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_en) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o = mem_q[rd_ptr_q];

    // A slot is occupied when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < int'(Depth); gi++) begin : g_slot
        logic [PtrW-1:0] offset;
        assign offset       = PtrW'(gi) - rd_ptr_q;
        assign valid_o[gi]  = (CntW'(offset) < count_q);
        assign entries_o[gi] = mem_q[gi];
    end

endmodule

// File: rtl/ibex_fp_wb_stage.sv
// ibex_fp_wb_stage: writeback stage behind EX. Buffers results in order,
// drains the head to the integer or FP regfile write port (the LSU load
// response has priority on each port), accumulates sticky fflags on
// retirement and flags ID source operands that match a pending rd.
//   ex_*           result from execute, accepted when ex_ready_o
//   lsu_we_i/lsu_rd_fp_i  load response occupying one write port
//   rf_* / fp_rf_* integer / FP regfile write ports (combinational)
//   fflags_*       CSR write path and accumulated flags
//   id_rs_*        ID source operands; id_hazard_o per-source hit
//   wb_empty_o     nothing buffered
module ibex_fp_wb_stage
    import ibex_pkg::*;
    import ibex_fp_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter bit          FpFlagsEn = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [31:0]         ex_result_i,
    input  logic [4:0]          ex_rd_addr_i,
    input  logic                ex_rd_fp_i,
    input  logic                ex_rd_we_i,
    input  logic [FFLAGS_W-1:0] ex_fflags_i,
    input  logic                ex_fflags_we_i,
    input  logic                lsu_we_i,
    input  logic                lsu_rd_fp_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_waddr_o,
    output logic [31:0]         rf_wdata_o,
    output logic                fp_rf_we_o,
    output logic [4:0]          fp_rf_waddr_o,
    output logic [31:0]         fp_rf_wdata_o,
    input  logic                fflags_wr_i,
    input  logic [FFLAGS_W-1:0] fflags_wdata_i,
    output logic [FFLAGS_W-1:0] fflags_o,
    input  logic [14:0]         id_rs_addr_i,
    input  logic [2:0]          id_rs_fp_i,
    output logic [2:0]          id_hazard_o,
    output logic                wb_empty_o
);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        entries [Depth];
    logic [Depth-1:0] valid;
    logic             full, empty;
    logic             push, pop, head_valid, port_busy;

    // Results that neither write a register nor report flags are accepted but not stored.
    assign ex_ready_o = ~full;
    assign push       = ex_valid_i & ex_ready_o & (ex_rd_we_i | ex_fflags_we_i);

    assign push_entry = '{
        rd_addr:   ex_rd_addr_i,
        rd_fp:     ex_rd_fp_i,
        rd_we:     ex_rd_we_i,
        result:    ex_result_i,
        fflags:    ex_fflags_i,
        fflags_we: ex_fflags_we_i
    };

    ibex_wb_fifo #(
        .Depth (Depth),
        .T     (wb_entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .data_i    (push_entry),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (full),
        .empty_o   (empty),
        .entries_o (entries),
        .valid_o   (valid)
    );

    // Strict in-order drain: a load on the head's port stalls everything behind it.
    assign head_valid = ~empty;
    assign port_busy  = lsu_we_i & (lsu_rd_fp_i == head.rd_fp);
    assign pop        = head_valid & ~port_busy;

    assign rf_we_o       = pop & head.rd_we & ~head.rd_fp & (head.rd_addr != 5'd0);
    assign fp_rf_we_o    = pop & head.rd_we & head.rd_fp;
    assign rf_waddr_o    = head_valid ? head.rd_addr : 5'd0;
    assign rf_wdata_o    = head_valid ? head.result : 32'd0;
    assign fp_rf_waddr_o = head_valid ? head.rd_addr : 5'd0;
    assign fp_rf_wdata_o = head_valid ? head.result : 32'd0;
    assign wb_empty_o    = empty;

    if (FpFlagsEn) begin : g_fflags
        logic [FFLAGS_W-1:0] fflags_q, fflags_d, ret_flags;

        // Retiring flags are OR-ed after the CSR write so they are never overwritten.
        always_comb begin
            ret_flags = (pop && head.fflags_we) ? head.fflags : '0;
            fflags_d  = (fflags_wr_i ? fflags_wdata_i : fflags_q) | ret_flags;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fflags_q <= '0;
            end else begin
                fflags_q <= fflags_d;
            end
        end

        assign fflags_o = fflags_q;
    end else begin : g_no_fflags
        logic unused_fflags;
        assign unused_fflags = ^{fflags_wr_i, fflags_wdata_i, head.fflags, head.fflags_we};
        assign fflags_o      = '0;
    end

    // Per-source, per-slot match. A popping entry still hits; integer x0 never does.
    logic [Depth-1:0] hit [3];

    for (genvar gi = 0; gi < int'(Depth); gi++) begin : g_haz_slot
        logic unused_payload;
        assign unused_payload = ^{entries[gi].result, entries[gi].fflags, entries[gi].fflags_we};
        for (genvar gr = 0; gr < 3; gr++) begin : g_haz_src
            assign hit[gr][gi] = valid[gi] & entries[gi].rd_we
                               & (entries[gi].rd_addr == id_rs_addr_i[gr*5 +: 5])
                               & (entries[gi].rd_fp == id_rs_fp_i[gr])
                               & (entries[gi].rd_fp | (entries[gi].rd_addr != 5'd0));
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_haz_out
        assign id_hazard_o[gr] = |hit[gr];
    end

endmodule
